// File: rtl/arbiter_cpu_regs_pkg.sv
// Shared definitions for the register-interface demo: register map, response
// codes, reset values, the master's fixed write/read script and small helpers.
package arbiter_cpu_regs_pkg;

  localparam int unsigned REG_BITS  = 32;
  localparam int unsigned STRB_BITS = REG_BITS / 8;

  localparam logic [7:0] ADDR_RO   = 8'h00;
  localparam logic [7:0] ADDR_WO   = 8'h04;
  localparam logic [7:0] ADDR_WOE  = 8'h08;
  localparam logic [7:0] ADDR_ROC  = 8'h0C;
  localparam logic [7:0] ADDR_RWS  = 8'h10;
  localparam logic [7:0] ADDR_RWCR = 8'h14;
  localparam logic [7:0] ADDR_RWCW = 8'h18;
  localparam logic [7:0] ADDR_RWA  = 8'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [REG_BITS-1:0] REG_RESET = '0;

  localparam int unsigned NUM_STEPS = 16;

  typedef struct packed {
    logic                wr;
    logic [7:0]          addr;
    logic [REG_BITS-1:0] data;
  } step_t;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WAIT,
    M_ISSUE,
    M_RESP,
    M_GAP,
    M_DONE
  } mst_state_t;

  // Six writes followed by ten reads; the last read targets an unmapped offset.
  function automatic step_t script_step(input logic [3:0] idx);
    step_t s;
    case (idx)
      4'd0:    s = '{wr: 1'b1, addr: ADDR_WO,   data: 32'h1111_1111};
      4'd1:    s = '{wr: 1'b1, addr: ADDR_WOE,  data: 32'h2222_2222};
      4'd2:    s = '{wr: 1'b1, addr: ADDR_RWS,  data: 32'h3333_3333};
      4'd3:    s = '{wr: 1'b1, addr: ADDR_RWCR, data: 32'h4444_4444};
      4'd4:    s = '{wr: 1'b1, addr: ADDR_RWCW, data: 32'h5555_5555};
      4'd5:    s = '{wr: 1'b1, addr: ADDR_RWA,  data: 32'h6666_6666};
      4'd6:    s = '{wr: 1'b0, addr: ADDR_RO,   data: REG_RESET};
      4'd7:    s = '{wr: 1'b0, addr: ADDR_WO,   data: REG_RESET};
      4'd8:    s = '{wr: 1'b0, addr: ADDR_ROC,  data: REG_RESET};
      4'd9:    s = '{wr: 1'b0, addr: ADDR_ROC,  data: REG_RESET};
      4'd10:   s = '{wr: 1'b0, addr: ADDR_RWS,  data: REG_RESET};
      4'd11:   s = '{wr: 1'b0, addr: ADDR_RWCR, data: REG_RESET};
      4'd12:   s = '{wr: 1'b0, addr: ADDR_RWCR, data: REG_RESET};
      4'd13:   s = '{wr: 1'b0, addr: ADDR_RWCW, data: REG_RESET};
      4'd14:   s = '{wr: 1'b0, addr: ADDR_RWA,  data: REG_RESET};
      default: s = '{wr: 1'b0, addr: 8'h20,     data: REG_RESET};
    endcase
    return s;
  endfunction

  function automatic logic is_mapped(input logic [7:0] addr);
    case (addr)
      ADDR_RO, ADDR_WO, ADDR_WOE, ADDR_ROC,
      ADDR_RWS, ADDR_RWCR, ADDR_RWCW, ADDR_RWA: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic [REG_BITS-1:0] apply_strb(input logic [REG_BITS-1:0]  cur,
                                                     input logic [REG_BITS-1:0]  nxt,
                                                     input logic [STRB_BITS-1:0] strb);
    logic [REG_BITS-1:0] res;
    res = cur;
    for (int unsigned b = 0; b < STRB_BITS; b++) begin
      if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/arbiter_cpu_regs.sv
// AXI4-Lite slave with the CPU-side register file.
// Ports: clk/rst_n; AXI write (aw*, w*, b*) and read (ar*, r*) channels with
// 8-bit decode addresses; IP-side values to read back (ro, roc, ip2cpu_*);
// CPU-side stored values, one-cycle WOE data, and one-cycle clear/load strobes.
module arbiter_cpu_regs
  import arbiter_cpu_regs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [REG_BITS-1:0]  wdata,
  input  logic [STRB_BITS-1:0] wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [7:0]           araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [REG_BITS-1:0]  rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  input  logic [REG_BITS-1:0]  ro_reg,
  input  logic [REG_BITS-1:0]  roc_reg,
  input  logic [REG_BITS-1:0]  ip2cpu_rwcr_reg,
  input  logic [REG_BITS-1:0]  ip2cpu_rwcw_reg,
  input  logic [REG_BITS-1:0]  ip2cpu_rwa_reg,
  output logic [REG_BITS-1:0]  wo_reg,
  output logic [REG_BITS-1:0]  woe_reg,
  output logic [REG_BITS-1:0]  rws_reg,
  output logic [REG_BITS-1:0]  cpu2ip_rwcr_reg,
  output logic [REG_BITS-1:0]  cpu2ip_rwcw_reg,
  output logic [REG_BITS-1:0]  cpu2ip_rwa_reg,
  output logic                 roc_reg_clear,
  output logic                 cpu2ip_rwcr_reg_clear,
  output logic                 cpu2ip_rwcr_reg_load,
  output logic                 cpu2ip_rwcw_reg_clear
);

  logic                wr_fire;
  logic                rd_fire;
  logic [REG_BITS-1:0] rd_mux;

  assign wr_fire = awvalid & awready & wvalid & wready;
  assign rd_fire = arvalid & arready;

  // Write-only registers and unmapped offsets read back as zero.
  always_comb begin
    rd_mux = REG_RESET;
    case (araddr)
      ADDR_RO:   rd_mux = ro_reg;
      ADDR_ROC:  rd_mux = roc_reg;
      ADDR_RWS:  rd_mux = rws_reg;
      ADDR_RWCR: rd_mux = ip2cpu_rwcr_reg;
      ADDR_RWCW: rd_mux = ip2cpu_rwcw_reg;
      ADDR_RWA:  rd_mux = ip2cpu_rwa_reg;
      default:   rd_mux = REG_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready               <= 1'b0;
      wready                <= 1'b0;
      bresp                 <= RESP_OKAY;
      bvalid                <= 1'b0;
      arready               <= 1'b0;
      rdata                 <= REG_RESET;
      rresp                 <= RESP_OKAY;
      rvalid                <= 1'b0;
      wo_reg                <= REG_RESET;
      woe_reg               <= REG_RESET;
      rws_reg               <= REG_RESET;
      cpu2ip_rwcr_reg       <= REG_RESET;
      cpu2ip_rwcw_reg       <= REG_RESET;
      cpu2ip_rwa_reg        <= REG_RESET;
      roc_reg_clear         <= 1'b0;
      cpu2ip_rwcr_reg_clear <= 1'b0;
      cpu2ip_rwcr_reg_load  <= 1'b0;
      cpu2ip_rwcw_reg_clear <= 1'b0;
    end else begin
      awready               <= 1'b0;
      wready                <= 1'b0;
      arready               <= 1'b0;
      woe_reg               <= REG_RESET;
      roc_reg_clear         <= 1'b0;
      cpu2ip_rwcr_reg_clear <= 1'b0;
      cpu2ip_rwcr_reg_load  <= 1'b0;
      cpu2ip_rwcw_reg_clear <= 1'b0;

      // Ready pulses only while no response is pending, so a second accept
      // cannot overlap the current one.
      if (awvalid && wvalid && !awready && !bvalid) begin
        awready <= 1'b1;
        wready  <= 1'b1;
      end

      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= is_mapped(awaddr) ? RESP_OKAY : RESP_SLVERR;
        case (awaddr)
          ADDR_WO:   wo_reg  <= apply_strb(wo_reg, wdata, wstrb);
          ADDR_WOE:  woe_reg <= wdata;
          ADDR_RWS:  rws_reg <= apply_strb(rws_reg, wdata, wstrb);
          ADDR_RWCR: begin
            cpu2ip_rwcr_reg      <= apply_strb(cpu2ip_rwcr_reg, wdata, wstrb);
            cpu2ip_rwcr_reg_load <= 1'b1;
          end
          ADDR_RWCW: begin
            cpu2ip_rwcw_reg       <= apply_strb(cpu2ip_rwcw_reg, wdata, wstrb);
            cpu2ip_rwcw_reg_clear <= 1'b1;
          end
          ADDR_RWA:  cpu2ip_rwa_reg <= apply_strb(cpu2ip_rwa_reg, wdata, wstrb);
          default:   ;
        endcase
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      if (arvalid && !arready && !rvalid) arready <= 1'b1;

      if (rd_fire) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
        rresp  <= is_mapped(araddr) ? RESP_OKAY : RESP_SLVERR;
        if (araddr == ADDR_ROC)  roc_reg_clear         <= 1'b1;
        if (araddr == ADDR_RWCR) cpu2ip_rwcr_reg_clear <= 1'b1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_if_top.sv
// Register-interface demo top: a scripted AXI4-Lite master drives the CPU
// register block while the IP-side counters and handshakes sit alongside.
// Ports: ACLK, ARESETN (async, active-low); read_AXI_* mirror every AXI
// channel signal; read_*_reg and read_*_clear(_d) mirror register state.
module reg_if_top
  import arbiter_cpu_regs_pkg::*;
#(
  parameter int unsigned START_DLY = 8,
  parameter int unsigned DATA_W    = REG_BITS
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  output logic [31:0]         read_AXI_AWADDR,
  output logic                read_AXI_AWVALID,
  output logic                read_AXI_AWREADY,
  output logic [DATA_W-1:0]   read_AXI_WDATA,
  output logic [DATA_W/8-1:0] read_AXI_WSTRB,
  output logic                read_AXI_WVALID,
  output logic                read_AXI_WREADY,
  output logic [1:0]          read_AXI_BRESP,
  output logic                read_AXI_BVALID,
  output logic                read_AXI_BREADY,
  output logic [31:0]         read_AXI_ARADDR,
  output logic                read_AXI_ARVALID,
  output logic                read_AXI_ARREADY,
  output logic [DATA_W-1:0]   read_AXI_RDATA,
  output logic [1:0]          read_AXI_RRESP,
  output logic                read_AXI_RVALID,
  output logic                read_AXI_RREADY,
  output logic [DATA_W-1:0]   read_ro_reg,
  output logic [DATA_W-1:0]   read_wo_reg,
  output logic [DATA_W-1:0]   read_woe_reg,
  output logic [DATA_W-1:0]   read_roc_reg,
  output logic [DATA_W-1:0]   read_rws_reg,
  output logic [DATA_W-1:0]   read_ip2cpu_rwcr_reg,
  output logic [DATA_W-1:0]   read_ip2cpu_rwcw_reg,
  output logic [DATA_W-1:0]   read_ip2cpu_rwa_reg,
  output logic [DATA_W-1:0]   read_cpu2ip_rwcr_reg,
  output logic [DATA_W-1:0]   read_cpu2ip_rwcw_reg,
  output logic [DATA_W-1:0]   read_cpu2ip_rwa_reg,
  output logic                read_roc_reg_clear,
  output logic                read_cpu2ip_rwcr_reg_clear,
  output logic                read_cpu2ip_rwcw_reg_clear,
  output logic                read_cpu2ip_rwcw_reg_clear_d
);

  mst_state_t state;
  logic [3:0]  step_idx;
  logic [15:0] dly_cnt;
  step_t       cur;
  logic        launch;
  logic        rwcr_load;

  assign cur = script_step(step_idx);

  // Start the current script step: after the start delay, or after the idle gap.
  assign launch = (state == M_IDLE && START_DLY <= 1) ||
                  (state == M_WAIT && dly_cnt == 16'(START_DLY - 1)) ||
                  (state == M_GAP);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state            <= M_IDLE;
      step_idx         <= '0;
      dly_cnt          <= '0;
      read_AXI_AWADDR  <= '0;
      read_AXI_AWVALID <= 1'b0;
      read_AXI_WDATA   <= '0;
      read_AXI_WSTRB   <= '0;
      read_AXI_WVALID  <= 1'b0;
      read_AXI_BREADY  <= 1'b0;
      read_AXI_ARADDR  <= '0;
      read_AXI_ARVALID <= 1'b0;
      read_AXI_RREADY  <= 1'b0;
    end else if (launch) begin
      state <= M_ISSUE;
      if (cur.wr) begin
        read_AXI_AWADDR  <= 32'(cur.addr);
        read_AXI_WDATA   <= cur.data;
        read_AXI_WSTRB   <= '1;
        read_AXI_AWVALID <= 1'b1;
        read_AXI_WVALID  <= 1'b1;
      end else begin
        read_AXI_ARADDR  <= 32'(cur.addr);
        read_AXI_ARVALID <= 1'b1;
      end
    end else begin
      case (state)
        M_IDLE: begin
          state   <= M_WAIT;
          dly_cnt <= 16'd1;
        end
        M_WAIT: dly_cnt <= dly_cnt + 16'd1;
        M_ISSUE: begin
          if (cur.wr) begin
            // Address and data channels retire independently.
            if (read_AXI_AWVALID && read_AXI_AWREADY) read_AXI_AWVALID <= 1'b0;
            if (read_AXI_WVALID && read_AXI_WREADY) begin
              read_AXI_WVALID <= 1'b0;
              read_AXI_WSTRB  <= '0;
            end
            if ((!read_AXI_AWVALID || read_AXI_AWREADY) &&
                (!read_AXI_WVALID || read_AXI_WREADY)) begin
              state           <= M_RESP;
              read_AXI_BREADY <= 1'b1;
            end
          end else if (read_AXI_ARREADY) begin
            read_AXI_ARVALID <= 1'b0;
            read_AXI_RREADY  <= 1'b1;
            state            <= M_RESP;
          end
        end
        M_RESP: begin
          if ((cur.wr && read_AXI_BVALID) || (!cur.wr && read_AXI_RVALID)) begin
            read_AXI_BREADY <= 1'b0;
            read_AXI_RREADY <= 1'b0;
            if (step_idx == 4'(NUM_STEPS - 1)) begin
              state <= M_DONE;
            end else begin
              step_idx <= step_idx + 4'd1;
              state    <= M_GAP;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // IP-side logic.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      read_ro_reg                  <= '0;
      read_roc_reg                 <= '0;
      read_ip2cpu_rwcr_reg         <= '0;
      read_ip2cpu_rwcw_reg         <= '0;
      read_ip2cpu_rwa_reg          <= '0;
      read_cpu2ip_rwcw_reg_clear_d <= 1'b0;
    end else begin
      read_ro_reg <= read_ro_reg + DATA_W'(1);

      if (read_roc_reg_clear) read_roc_reg <= '0;
      else                    read_roc_reg <= read_roc_reg + DATA_W'(1);

      if (read_cpu2ip_rwcr_reg_clear) read_ip2cpu_rwcr_reg <= '0;
      else if (rwcr_load)             read_ip2cpu_rwcr_reg <= read_cpu2ip_rwcr_reg;

      read_cpu2ip_rwcw_reg_clear_d <= read_cpu2ip_rwcw_reg_clear;
      if (read_cpu2ip_rwcw_reg_clear_d) read_ip2cpu_rwcw_reg <= '0;
      else                              read_ip2cpu_rwcw_reg <= read_ip2cpu_rwcw_reg + DATA_W'(1);

      read_ip2cpu_rwa_reg <= read_cpu2ip_rwa_reg;
    end
  end

  arbiter_cpu_regs u_regs (
    .clk                   (ACLK),
    .rst_n                 (ARESETN),
    .awaddr                (read_AXI_AWADDR[7:0]),
    .awvalid               (read_AXI_AWVALID),
    .awready               (read_AXI_AWREADY),
    .wdata                 (read_AXI_WDATA),
    .wstrb                 (read_AXI_WSTRB),
    .wvalid                (read_AXI_WVALID),
    .wready                (read_AXI_WREADY),
    .bresp                 (read_AXI_BRESP),
    .bvalid                (read_AXI_BVALID),
    .bready                (read_AXI_BREADY),
    .araddr                (read_AXI_ARADDR[7:0]),
    .arvalid               (read_AXI_ARVALID),
    .arready               (read_AXI_ARREADY),
    .rdata                 (read_AXI_RDATA),
    .rresp                 (read_AXI_RRESP),
    .rvalid                (read_AXI_RVALID),
    .rready                (read_AXI_RREADY),
    .ro_reg                (read_ro_reg),
    .roc_reg               (read_roc_reg),
    .ip2cpu_rwcr_reg       (read_ip2cpu_rwcr_reg),
    .ip2cpu_rwcw_reg       (read_ip2cpu_rwcw_reg),
    .ip2cpu_rwa_reg        (read_ip2cpu_rwa_reg),
    .wo_reg                (read_wo_reg),
    .woe_reg               (read_woe_reg),
    .rws_reg               (read_rws_reg),
    .cpu2ip_rwcr_reg       (read_cpu2ip_rwcr_reg),
    .cpu2ip_rwcw_reg       (read_cpu2ip_rwcw_reg),
    .cpu2ip_rwa_reg        (read_cpu2ip_rwa_reg),
    .roc_reg_clear         (read_roc_reg_clear),
    .cpu2ip_rwcr_reg_clear (read_cpu2ip_rwcr_reg_clear),
    .cpu2ip_rwcr_reg_load  (rwcr_load),
    .cpu2ip_rwcw_reg_clear (read_cpu2ip_rwcw_reg_clear)
  );

endmodule

// File: tb/tb_reg_if_top.sv
// Directed bench for reg_if_top. The script is fixed, so every transaction
// lands on a known cycle: step k starts after edge 8+4k and its handshake
// completes on edge 10+4k (edges counted from reset release).
module tb_reg_if_top;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] ro, wo, woe, roc, rws, ip_rwcr, ip_rwcw, ip_rwa, cp_rwcr, cp_rwcw, cp_rwa;
  logic        roc_clr, rwcr_clr, rwcw_clr, rwcw_clr_d;

  int unsigned cyc;
  int          total = 0;
  int          bad = 0;

  reg_if_top #(.START_DLY(8), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .read_AXI_AWADDR(awaddr), .read_AXI_AWVALID(awvalid), .read_AXI_AWREADY(awready),
    .read_AXI_WDATA(wdata), .read_AXI_WSTRB(wstrb), .read_AXI_WVALID(wvalid), .read_AXI_WREADY(wready),
    .read_AXI_BRESP(bresp), .read_AXI_BVALID(bvalid), .read_AXI_BREADY(bready),
    .read_AXI_ARADDR(araddr), .read_AXI_ARVALID(arvalid), .read_AXI_ARREADY(arready),
    .read_AXI_RDATA(rdata), .read_AXI_RRESP(rresp), .read_AXI_RVALID(rvalid), .read_AXI_RREADY(rready),
    .read_ro_reg(ro), .read_wo_reg(wo), .read_woe_reg(woe), .read_roc_reg(roc), .read_rws_reg(rws),
    .read_ip2cpu_rwcr_reg(ip_rwcr), .read_ip2cpu_rwcw_reg(ip_rwcw), .read_ip2cpu_rwa_reg(ip_rwa),
    .read_cpu2ip_rwcr_reg(cp_rwcr), .read_cpu2ip_rwcw_reg(cp_rwcw), .read_cpu2ip_rwa_reg(cp_rwa),
    .read_roc_reg_clear(roc_clr), .read_cpu2ip_rwcr_reg_clear(rwcr_clr),
    .read_cpu2ip_rwcw_reg_clear(rwcw_clr), .read_cpu2ip_rwcw_reg_clear_d(rwcw_clr_d)
  );

  always #5 ACLK = ~ACLK;

  // Edges since reset release.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Advance to the negedge that follows edge n.
  task automatic wait_cyc(input int unsigned n);
    int unsigned guard;
    guard = 0;
    @(negedge ACLK);
    while (cyc < n && guard < 500) begin
      @(negedge ACLK);
      guard++;
    end
    total++;
    if (cyc != n) begin bad++; $display("FAIL wait_cyc got=%0d want=%0d", cyc, n); end
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    repeat (16) @(negedge ACLK);
    total++; if ({awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready} !== 10'b0) begin bad++; $display("FAIL reset_handshake got=%b want=0", {awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready}); end
    total++; if ({wstrb, bresp, rresp} !== 8'h00) begin bad++; $display("FAIL reset_strb_resp got=%h want=00", {wstrb, bresp, rresp}); end
    total++; if ((awaddr | wdata | araddr | rdata) !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h want=0", awaddr | wdata | araddr | rdata); end
    total++; if ((ro | wo | woe | roc | rws | ip_rwcr | ip_rwcw | ip_rwa | cp_rwcr | cp_rwcw | cp_rwa) !== 32'h0) begin bad++; $display("FAIL reset_regs got=%h want=0", ro | wo | woe | roc | rws | ip_rwcr | ip_rwcw | ip_rwa | cp_rwcr | cp_rwcw | cp_rwa); end
    total++; if ({roc_clr, rwcr_clr, rwcw_clr, rwcw_clr_d} !== 4'b0) begin bad++; $display("FAIL reset_clears got=%b want=0", {roc_clr, rwcr_clr, rwcw_clr, rwcw_clr_d}); end
    ARESETN = 1'b1;
  endtask

  task automatic test_start_delay;
    for (int unsigned i = 1; i <= 7; i++) begin
      wait_cyc(i);
      total++; if ({awvalid, wvalid, arvalid} !== 3'b0) begin bad++; $display("FAIL start_quiet cyc=%0d got=%b want=000", i, {awvalid, wvalid, arvalid}); end
    end
    wait_cyc(8);
    total++; if ({awvalid, wvalid, arvalid} !== 3'b110) begin bad++; $display("FAIL first_valid got=%b want=110", {awvalid, wvalid, arvalid}); end
    total++; if (wstrb !== 4'hF) begin bad++; $display("FAIL first_wstrb got=%h want=f", wstrb); end
    total++; if (awaddr !== 32'h04 || wdata !== 32'h1111_1111) begin bad++; $display("FAIL first_aw got=%h/%h want=4/11111111", awaddr, wdata); end
    wait_cyc(9);
    total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL ready_pulse got=%b want=11", {awready, wready}); end
    wait_cyc(10);
    total++; if ({awvalid, wvalid, awready, wready, bvalid, bready} !== 6'b000011) begin bad++; $display("FAIL wo_bresp_phase got=%b want=000011", {awvalid, wvalid, awready, wready, bvalid, bready}); end
    total++; if (wo !== 32'h1111_1111) begin bad++; $display("FAIL wo_store got=%h want=11111111", wo); end
    wait_cyc(11);
    total++; if ({bvalid, bready, awvalid} !== 3'b000) begin bad++; $display("FAIL gap_cycle got=%b want=000", {bvalid, bready, awvalid}); end
  endtask

  task automatic test_woe;
    wait_cyc(13);
    total++; if (woe !== 32'h0) begin bad++; $display("FAIL woe_before got=%h want=0", woe); end
    wait_cyc(14);
    total++; if (woe !== 32'h2222_2222) begin bad++; $display("FAIL woe_pulse got=%h want=22222222", woe); end
    total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("FAIL woe_bresp got=%b/%b want=1/00", bvalid, bresp); end
    wait_cyc(15);
    total++; if (woe !== 32'h0) begin bad++; $display("FAIL woe_after got=%h want=0", woe); end
  endtask

  task automatic test_rwcr_write;
    wait_cyc(22);
    total++; if (cp_rwcr !== 32'h4444_4444 || ip_rwcr !== 32'h0) begin bad++; $display("FAIL rwcr_write got=%h/%h want=44444444/0", cp_rwcr, ip_rwcr); end
    wait_cyc(23);
    total++; if (ip_rwcr !== 32'h4444_4444) begin bad++; $display("FAIL rwcr_load got=%h want=44444444", ip_rwcr); end
  endtask

  task automatic test_rwcw_write;
    wait_cyc(26);
    total++; if (cp_rwcw !== 32'h5555_5555 || {rwcw_clr, rwcw_clr_d} !== 2'b10) begin bad++; $display("FAIL rwcw_write got=%h/%b want=55555555/10", cp_rwcw, {rwcw_clr, rwcw_clr_d}); end
    wait_cyc(27);
    total++; if ({rwcw_clr, rwcw_clr_d} !== 2'b01 || ip_rwcw !== 32'd27) begin bad++; $display("FAIL rwcw_clear_d got=%b/%0d want=01/27", {rwcw_clr, rwcw_clr_d}, ip_rwcw); end
    wait_cyc(28);
    total++; if (ip_rwcw !== 32'd0 || rwcw_clr_d !== 1'b0) begin bad++; $display("FAIL rwcw_zero got=%0d/%b want=0/0", ip_rwcw, rwcw_clr_d); end
  endtask

  task automatic test_rwa;
    wait_cyc(30);
    total++; if (cp_rwa !== 32'h6666_6666 || ip_rwa !== 32'h0) begin bad++; $display("FAIL rwa_write got=%h/%h want=66666666/0", cp_rwa, ip_rwa); end
    wait_cyc(31);
    total++; if (ip_rwa !== 32'h6666_6666) begin bad++; $display("FAIL rwa_follow got=%h want=66666666", ip_rwa); end
  endtask

  task automatic test_reads;
    wait_cyc(34);
    total++; if (rvalid !== 1'b1 || rdata !== 32'd33 || rresp !== 2'b00) begin bad++; $display("FAIL read_ro got=%b/%0d/%b want=1/33/00", rvalid, rdata, rresp); end
    wait_cyc(38);
    total++; if (rdata !== 32'h0 || rresp !== 2'b00) begin bad++; $display("FAIL read_wo got=%h/%b want=0/00", rdata, rresp); end
    wait_cyc(42);
    total++; if (rdata !== 32'd41 || roc_clr !== 1'b1) begin bad++; $display("FAIL read_roc1 got=%0d/%b want=41/1", rdata, roc_clr); end
    wait_cyc(43);
    total++; if (roc_clr !== 1'b0 || roc !== 32'd0) begin bad++; $display("FAIL roc_cleared got=%b/%0d want=0/0", roc_clr, roc); end
    wait_cyc(46);
    total++; if (rdata !== 32'd2 || roc_clr !== 1'b1) begin bad++; $display("FAIL read_roc2 got=%0d/%b want=2/1", rdata, roc_clr); end
    wait_cyc(47);
    total++; if (roc_clr !== 1'b0) begin bad++; $display("FAIL roc_clr_len got=%b want=0", roc_clr); end
    wait_cyc(50);
    total++; if (rdata !== 32'h3333_3333) begin bad++; $display("FAIL read_rws got=%h want=33333333", rdata); end
    wait_cyc(54);
    total++; if (rdata !== 32'h4444_4444 || rwcr_clr !== 1'b1) begin bad++; $display("FAIL read_rwcr1 got=%h/%b want=44444444/1", rdata, rwcr_clr); end
    wait_cyc(55);
    total++; if (ip_rwcr !== 32'h0 || rwcr_clr !== 1'b0) begin bad++; $display("FAIL rwcr_cleared got=%h/%b want=0/0", ip_rwcr, rwcr_clr); end
    wait_cyc(58);
    total++; if (rdata !== 32'h0 || rresp !== 2'b00) begin bad++; $display("FAIL read_rwcr2 got=%h/%b want=0/00", rdata, rresp); end
    wait_cyc(62);
    total++; if (rdata !== 32'd33) begin bad++; $display("FAIL read_rwcw got=%0d want=33", rdata); end
    wait_cyc(66);
    total++; if (rdata !== 32'h6666_6666) begin bad++; $display("FAIL read_rwa got=%h want=66666666", rdata); end
    wait_cyc(70);
    total++; if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin bad++; $display("FAIL read_unmapped got=%b/%b/%h want=1/10/0", rvalid, rresp, rdata); end
  endtask

  task automatic test_done;
    for (int unsigned i = 72; i <= 90; i++) begin
      wait_cyc(i);
      total++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin bad++; $display("FAIL done_idle cyc=%0d got=%b want=0", i, {awvalid, wvalid, arvalid, bready, rready}); end
    end
  endtask

  task automatic test_mid_reset;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    wait_cyc(9);
    total++; if ({awvalid, awready} !== 2'b11) begin bad++; $display("FAIL mid_setup got=%b want=11", {awvalid, awready}); end
    #1 ARESETN = 1'b0;
    #1;
    total++; if ({awvalid, awready, wvalid, wready, wstrb} !== 8'h00 || ro !== 32'h0) begin bad++; $display("FAIL mid_async got=%b/%h want=0/0", {awvalid, awready, wvalid, wready, wstrb}, ro); end
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    wait_cyc(7);
    total++; if ({awvalid, wvalid, arvalid} !== 3'b0) begin bad++; $display("FAIL restart_quiet got=%b want=000", {awvalid, wvalid, arvalid}); end
    wait_cyc(8);
    total++; if (awvalid !== 1'b1 || awaddr !== 32'h04 || wdata !== 32'h1111_1111) begin bad++; $display("FAIL restart_step1 got=%b/%h/%h want=1/4/11111111", awvalid, awaddr, wdata); end
    wait_cyc(10);
    total++; if (bvalid !== 1'b1 || wo !== 32'h1111_1111) begin bad++; $display("FAIL restart_write got=%b/%h want=1/11111111", bvalid, wo); end
  endtask

  initial begin
    test_reset();
    test_start_delay();
    test_woe();
    test_rwcr_write();
    test_rwcw_write();
    test_rwa();
    test_reads();
    test_done();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
